// File: rtl/step_delay_pkg.sv
// Shared types and defaults for the stepper delay timer.
// State encoding and the board-clock tick length.
package step_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // 1 ms at the 50 MHz board clock
  localparam int TICK_CYCLES_DEF = 50000;

endpackage

// File: rtl/step_delay_timer_tick_prescaler.sv
// Divides clk down to one tick per TICK_CYCLES advanced cycles.
// tick_o is high in the cycle the counter wraps.
module tick_prescaler #(
  parameter int TICK_CYCLES = 50000,
  parameter int PRE_W       = 16
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic advance_i,
  output logic tick_o
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == LAST);
  assign tick_o = advance_i & wrap & ~clear_i;

  // next count: clear wins, otherwise step and wrap at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (advance_i)
      cnt_d = wrap ? '0 : cnt_q + PRE_W'(1);
  end

  // prescaler register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_delay_timer.sv
// Delay timer pacing the stepper step loops and PAUSE.
// Optional macro STEP_DELAY_HOLD_EN adds hold_n to freeze counting.
module step_delay_timer
  import step_delay_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int VAL_W       = 8,
  parameter int PRE_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_delay_counter,
  input  logic             enable_delay_counter,
  input  logic [VAL_W-1:0] delay_value,
  output logic             delay_done,
  output logic             busy
`ifdef STEP_DELAY_HOLD_EN
  ,
  input  logic             hold_n
`endif
);

  state_e           state_q;
  logic [VAL_W-1:0] unit_q;
  logic             done_q;
  logic             busy_q;
  logic             run;
  logic             advance;
  logic             tick;

`ifdef STEP_DELAY_HOLD_EN
  assign run = enable_delay_counter & hold_n;
`else
  assign run = enable_delay_counter;
`endif

  // start overrides counting in its own cycle
  assign advance = (state_q == COUNT) & run
                 & ~start_delay_counter;

  assign delay_done = done_q;
  assign busy       = busy_q;

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES),
    .PRE_W       (PRE_W)
  ) u_pre (
    .clk       (clk),
    .reset_n_i (reset_n),
    .clear_i   (start_delay_counter),
    .advance_i (advance),
    .tick_o    (tick)
  );

  // state machine, unit counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      unit_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_delay_counter) begin
      if (delay_value != '0) begin
        state_q <= COUNT;
        unit_q  <= delay_value;
        done_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        state_q <= DONE;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        COUNT: begin
          if (tick) begin
            unit_q <= unit_q - VAL_W'(1);
            if (unit_q == VAL_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
